id_ex_stage: RTL
================

Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select stage sitting directly upstream of the ALU.
- Latches decoded instruction fields and register-file read data each cycle.
- Applies EX/MEM and MEM/WB forwarding, and selects the immediate or register operand.
- Drives the ALU inputs reg1data, ALU2, ALUfunc and shamt; detects load-use hazards and inserts bubbles.

Parameters:
- DW, 32, datapath width.
- RW, 5, register index width.

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- stall  in  1  hold all stage state
- flush  in  1  replace the incoming instruction with a bubble
- id_valid  in  1  decode stage holds a real instruction
- id_rs_data, id_rt_data  in  DW  register-file read data
- id_imm  in  16  instruction immediate
- id_rs, id_rt, id_rd  in  RW  register indices
- id_shamt  in  5  shift amount
- id_ALUfunc  in  4  ALU function code
- id_ALUSrc  in  1  1 = immediate operand to ALU2
- id_zext  in  1  1 = zero-extend the immediate, 0 = sign-extend
- id_RegDst  in  1  1 = destination is rd, 0 = rt
- id_uses_rt  in  1  instruction reads rt
- id_regwrite, id_memread, id_memwrite, id_memtoreg  in  1  control bits
- exmem_regwrite  in  1  forwarding source 1: write enable
- exmem_rd  in  RW  forwarding source 1: destination
- exmem_ALUOut  in  DW  forwarding source 1: data
- memwb_regwrite  in  1  forwarding source 2: write enable
- memwb_rd  in  RW  forwarding source 2: destination
- memwb_data  in  DW  forwarding source 2: data
- reg1data  out  DW  ALU operand A, forwarded
- ALU2  out  DW  ALU operand B: forwarded rt or extended immediate
- ALUfunc  out  4  registered function code
- shamt  out  5  registered shift amount
- ex_store_data  out  DW  forwarded rt value for sw
- ex_dst  out  RW  registered destination index
- ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg  out  1  registered control bits
- hazard  out  1  load-use hazard; decode and fetch must hold

Behaviour:
- Reset: every registered field is cleared to 0, so ex_valid=0, ALUfunc=0, shamt=0, ex_dst=0 and all control bits are 0.
  - reg1data, ALU2 and ex_store_data then read 0, unless a forwarding path matches a nonzero register.
  - Reset asserted mid-operation discards the in-flight instruction.
- Update priority on each edge: reset > flush > stall > hazard > load.
  - flush: load a bubble (valid and all control bits 0, all other fields 0).
  - stall: hold every register unchanged.
  - hazard with no stall: load a bubble.
  - Otherwise: load all id_* fields; ex_valid=id_valid; ex_dst=id_RegDst?id_rd:id_rt.
  - When id_valid=0, control bits are loaded as 0.
- Write-through on capture: if memwb_regwrite and memwb_rd!=0 and memwb_rd==id_rs, latch memwb_data instead of id_rs_data. The same rule applies to rt.
- Immediate: imm_ext = id_zext ? {16'b0,imm} : {{16{imm[15]}},imm}.
  - Computed at capture time and stored as DW bits.
- Forwarding is combinational from the registered indices, applied separately to rs and rt:
  - EX/MEM when exmem_regwrite and exmem_rd!=0 and exmem_rd==index.
  - Else MEM/WB when memwb_regwrite and memwb_rd!=0 and memwb_rd==index.
  - Else the latched data.
  - EX/MEM has priority when both sources match. Register 0 always reads the latched value.
- Outputs: reg1data=fwd_rs; ALU2=ex_ALUSrc?imm_ext:fwd_rt; ex_store_data=fwd_rt.
- Latency: one cycle from ID inputs to ALU inputs. Forwarding adds no latency.
- hazard is combinational and is 1 iff all of the following hold:
  - ex_valid and ex_memread and ex_dst!=0;
  - id_valid;
  - ex_dst==id_rs, or (id_uses_rt and ex_dst==id_rt).
- Hazard timing:
  - hazard is independent of stall and flush.
  - Exactly one bubble is inserted per load-use pair: after the bubble, the EX stage holds no load, so hazard drops.
  - While stall=1, hazard may stay high and no bubble is inserted.
- Bubbles never assert any write or memory control, so a flushed or bubbled instruction has no side effects downstream.

Test Plan:
- Reset, then load add with rs_data=5, rt_data=7, ALUfunc=0010 -> next cycle reg1data=5, ALU2=7, ALUfunc=0010, ex_valid=1, ex_regwrite=1.
- addi with imm=16'hFFFC, zext=0, ALUSrc=1 -> ALU2=32'hFFFFFFFC. Same imm with zext=1 (ori) -> ALU2=32'h0000FFFC.
- EX holds rs=3; exmem_rd=3 (data 11) and memwb_rd=3 (data 22) both writing -> reg1data=11. Drop exmem_regwrite -> reg1data=22. Same case with rs=0 -> latched value, no forward.
- lw to $4 in EX, ID instruction reads rt=$4 with uses_rt=1 -> hazard=1; next edge ex_valid=0 with controls 0, hazard=0. Assert stall while hazard=1 -> state held, no bubble.
- flush and stall both asserted with id_valid=1 -> bubble loaded (flush wins). Assert reset mid-stream -> all outputs 0 next edge.
- Capture-time write-through: memwb writes $6=0xABCD in the same cycle ID latches rs=$6 with stale id_rs_data=0 -> reg1data=0xABCD after memwb deasserts.

Source files
------------

// File: rtl/id_ex_stage.sv
// id_ex_stage -- ID/EX pipeline register and ALU operand-select stage.
//
// Latches the decoded instruction and register-file read data once per cycle.
// Forwards from EX/MEM and MEM/WB onto the latched operands. Selects the
// immediate or the register operand for ALU input B. Detects load-use hazards
// and replaces the stalled consumer with a bubble.
//
// Ports
//   clk, reset        rising-edge clock, synchronous active-high reset
//   stall, flush      hold stage / load bubble instead of the ID instruction
//   id_*              decoded instruction fields, read data, control bits
//   exmem_*, memwb_*  forwarding sources (write enable, destination, data)
//   reg1data, ALU2    ALU operands A and B (forwarded)
//   ALUfunc, shamt    registered function code and shift amount
//   ex_store_data     forwarded rt value for stores
//   ex_dst, ex_*      registered destination and control bits
//   hazard            load-use hazard; decode and fetch must hold
module id_ex_stage #(
  parameter int DW = 32,
  parameter int RW = 5
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [15:0]   id_imm,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic [RW-1:0] id_rd,
  input  logic [4:0]    id_shamt,
  input  logic [3:0]    id_ALUfunc,
  input  logic          id_ALUSrc,
  input  logic          id_zext,
  input  logic          id_RegDst,
  input  logic          id_uses_rt,
  input  logic          id_regwrite,
  input  logic          id_memread,
  input  logic          id_memwrite,
  input  logic          id_memtoreg,
  input  logic          exmem_regwrite,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_ALUOut,
  input  logic          memwb_regwrite,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_data,
  output logic [DW-1:0] reg1data,
  output logic [DW-1:0] ALU2,
  output logic [3:0]    ALUfunc,
  output logic [4:0]    shamt,
  output logic [DW-1:0] ex_store_data,
  output logic [RW-1:0] ex_dst,
  output logic          ex_valid,
  output logic          ex_regwrite,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_memtoreg,
  output logic          hazard
);

  // Complete stage state. A bubble is the all-zero value, so flush, hazard
  // and reset all load '0 and a bubble can never write anything downstream.
  typedef struct packed {
    logic          valid;
    logic          regwrite;
    logic          memread;
    logic          memwrite;
    logic          memtoreg;
    logic          alusrc;
    logic [3:0]    func;
    logic [4:0]    shamt;
    logic [RW-1:0] dst;
    logic [RW-1:0] rs;
    logic [RW-1:0] rt;
    logic [DW-1:0] rs_data;
    logic [DW-1:0] rt_data;
    logic [DW-1:0] imm;
  } ex_t;

  ex_t ex_q, ex_d, cap;
  logic [DW-1:0] fwd_rs, fwd_rt;

  // Load-use: the consumer in ID needs a value that the load in EX has not
  // fetched yet. This is deliberately independent of stall and flush.
  assign hazard = ex_q.valid && ex_q.memread && (ex_q.dst != '0) && id_valid &&
                  ((ex_q.dst == id_rs) || (id_uses_rt && (ex_q.dst == id_rt)));

  // Value captured from ID. The register file does not write-through
  // internally, so a MEM/WB write in the capture cycle is picked up here.
  always_comb begin
    cap          = '0;
    cap.valid    = id_valid;
    cap.regwrite = id_valid & id_regwrite;
    cap.memread  = id_valid & id_memread;
    cap.memwrite = id_valid & id_memwrite;
    cap.memtoreg = id_valid & id_memtoreg;
    cap.alusrc   = id_ALUSrc;
    cap.func     = id_ALUfunc;
    cap.shamt    = id_shamt;
    cap.dst      = id_RegDst ? id_rd : id_rt;
    cap.rs       = id_rs;
    cap.rt       = id_rt;
    cap.rs_data  = (memwb_regwrite && memwb_rd != '0 && memwb_rd == id_rs)
                   ? memwb_data : id_rs_data;
    cap.rt_data  = (memwb_regwrite && memwb_rd != '0 && memwb_rd == id_rt)
                   ? memwb_data : id_rt_data;
    cap.imm      = id_zext ? {{(DW-16){1'b0}}, id_imm}
                           : {{(DW-16){id_imm[15]}}, id_imm};
  end

  always_comb begin
    ex_d = ex_q;
    if (flush)       ex_d = '0;
    else if (stall)  ex_d = ex_q;
    else if (hazard) ex_d = '0;
    else             ex_d = cap;
  end

  always_ff @(posedge clk) begin
    if (reset) ex_q <= '0;
    else       ex_q <= ex_d;
  end

  // Forwarding. EX/MEM is the younger result, so it wins. Register 0 never
  // forwards.
  always_comb begin
    fwd_rs = ex_q.rs_data;
    if (exmem_regwrite && exmem_rd != '0 && exmem_rd == ex_q.rs)
      fwd_rs = exmem_ALUOut;
    else if (memwb_regwrite && memwb_rd != '0 && memwb_rd == ex_q.rs)
      fwd_rs = memwb_data;
  end

  always_comb begin
    fwd_rt = ex_q.rt_data;
    if (exmem_regwrite && exmem_rd != '0 && exmem_rd == ex_q.rt)
      fwd_rt = exmem_ALUOut;
    else if (memwb_regwrite && memwb_rd != '0 && memwb_rd == ex_q.rt)
      fwd_rt = memwb_data;
  end

  assign reg1data      = fwd_rs;
  assign ALU2          = ex_q.alusrc ? ex_q.imm : fwd_rt;
  assign ex_store_data = fwd_rt;
  assign ALUfunc       = ex_q.func;
  assign shamt         = ex_q.shamt;
  assign ex_dst        = ex_q.dst;
  assign ex_valid      = ex_q.valid;
  assign ex_regwrite   = ex_q.regwrite;
  assign ex_memread    = ex_q.memread;
  assign ex_memwrite   = ex_q.memwrite;
  assign ex_memtoreg   = ex_q.memtoreg;

endmodule
